// File: rtl/display_pkg.sv
// Shared constants, field positions and types for the display-state writer.
// Optional clipping of off-screen bullets is enabled by DISPLAY_STATE_CLIP_EN.
package display_pkg;

    localparam int VIDEO_WIDTH  = 640;
    localparam int VIDEO_HEIGHT = 480;
    localparam int BULLET_SIZE  = 12;
    localparam int SPRITE_SIZE  = 64;

    // Bullet word layout: x in [31:22], y in [21:13], active flag at [3]
    localparam int BX_MSB      = 31;
    localparam int BX_LSB      = 22;
    localparam int BY_MSB      = 21;
    localparam int BY_LSB      = 13;
    localparam int BACTIVE_BIT = 3;

    // CPU word-address map
    localparam int BULLET_BASE = 0;
    localparam int SPRITE_BASE = 64;

    typedef enum logic {CLEAN, DIRTY} commitState_t;

    // Deactivate a bullet whose top-left corner would push it past the screen edge
    function automatic logic [31:0] clipBullet(input logic [31:0] word);
        logic [31:0] res;
        res = word;
        if (int'(word[BX_MSB:BX_LSB]) > VIDEO_WIDTH - BULLET_SIZE ||
            int'(word[BY_MSB:BY_LSB]) > VIDEO_HEIGHT - BULLET_SIZE)
            res[BACTIVE_BIT] = 1'b0;
        return res;
    endfunction

endpackage

// File: rtl/frame_commit_ctrl.sv
// Commit controller: tracks whether the shadow bank has unpublished stores,
// decides when the copy to the visible bank happens, and counts frames.
module frame_commit_ctrl
    import display_pkg::*;
#(
    parameter int FCNT_W = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              frameEnd,
    input  logic              validWr,
    input  logic              lock,
    output logic              commitEn,
    output logic              commitPulse,
    output logic              dirty,
    output logic [FCNT_W-1:0] frameCount
);

    commitState_t state, stateNext;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= CLEAN;
        else         state <= stateNext;
    end

    // Next state; a store in the commit cycle wins over the clear
    always_comb begin
        stateNext = state;
        commitEn  = 1'b0;
        if (state == DIRTY && frameEnd && !lock) begin
            commitEn  = 1'b1;
            stateNext = CLEAN;
        end
        if (validWr) stateNext = DIRTY;
    end

    // Commit pulse lands the cycle after the copy edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) commitPulse <= 1'b0;
        else         commitPulse <= commitEn;
    end

    // Free-running frame counter, wraps naturally
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)       frameCount <= '0;
        else if (frameEnd) frameCount <= frameCount + 1'b1;
    end

    assign dirty = (state == DIRTY);

endmodule

// File: rtl/display_state_writer.sv
// Double-buffered CPU writer for the renderer's bullet/sprite buses.
// Stores go to a shadow bank; the whole bank is published at a frame boundary.
// Define DISPLAY_STATE_CLIP_EN to clear the active bit of off-screen bullets.
module display_state_writer
    import display_pkg::*;
#(
    parameter int NUM_BULLETS = 64,
    parameter int NUM_SPRITES = 4,
    parameter int ADDR_W      = 7,
    parameter int FCNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      frame_end,
    input  logic                      wr_en,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [31:0]               wr_data,
    input  logic                      lock,
    output logic [31:0]               rd_data,
    output logic                      commit_pulse,
    output logic                      dirty,
    output logic [FCNT_W-1:0]         frame_count,
    output logic [32*NUM_BULLETS-1:0] allBulletContents,
    output logic [32*NUM_SPRITES-1:0] allSpriteContents
);

    localparam int NUM_WORDS = NUM_BULLETS + NUM_SPRITES;
    localparam logic [ADDR_W-1:0] WORDS_A = ADDR_W'(NUM_WORDS);

    logic [NUM_WORDS-1:0][31:0] shadow;
    logic                       inRange;
    logic                       validWr;
    logic                       commitEn;
    logic [31:0]                storeData;

    assign inRange = (addr < WORDS_A);
    assign validWr = wr_en && inRange;

`ifdef DISPLAY_STATE_CLIP_EN
    localparam logic [ADDR_W-1:0] SPRITE_A = ADDR_W'(NUM_BULLETS);
    logic isBullet;
    assign isBullet  = (addr < SPRITE_A);
    assign storeData = isBullet ? clipBullet(wr_data) : wr_data;
`else
    assign storeData = wr_data;
`endif

    frame_commit_ctrl #(.FCNT_W(FCNT_W)) uCommit (
        .clk         (clk),
        .resetn      (resetn),
        .frameEnd    (frame_end),
        .validWr     (validWr),
        .lock        (lock),
        .commitEn    (commitEn),
        .commitPulse (commit_pulse),
        .dirty       (dirty),
        .frameCount  (frame_count)
    );

    // Shadow bank takes CPU stores; reset discards anything pending
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)      shadow        <= '0;
        else if (validWr) shadow[addr]  <= storeData;
    end

    // Registered readback sees the pre-store value on a same-cycle write
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)      rd_data <= '0;
        else if (inRange) rd_data <= shadow[addr];
        else              rd_data <= '0;
    end

    // Visible bank copies the pre-edge shadow in one shot on commit
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            allBulletContents <= '0;
            allSpriteContents <= '0;
        end else if (commitEn) begin
            allBulletContents <= shadow[NUM_BULLETS-1:0];
            allSpriteContents <= shadow[NUM_WORDS-1:NUM_BULLETS];
        end
    end

endmodule

// File: tb/tb_display_state_writer.sv
// Self-checking bench for display_state_writer: directed scenarios plus
// random traffic compared against a bank-level reference model.
module tb_display_state_writer;

    localparam int NB = 64;
    localparam int NS = 4;
    localparam int NT = NB + NS;

    logic           clk = 1'b0;
    logic           resetn;
    logic           frame_end;
    logic           wr_en;
    logic [6:0]     addr;
    logic [31:0]    wr_data;
    logic           lock;
    logic [31:0]    rd_data;
    logic           commit_pulse;
    logic           dirty;
    logic [15:0]    frame_count;
    logic [32*NB-1:0] allBulletContents;
    logic [32*NS-1:0] allSpriteContents;

    display_state_writer dut (
        .clk               (clk),
        .resetn            (resetn),
        .frame_end         (frame_end),
        .wr_en             (wr_en),
        .addr              (addr),
        .wr_data           (wr_data),
        .lock              (lock),
        .rd_data           (rd_data),
        .commit_pulse      (commit_pulse),
        .dirty             (dirty),
        .frame_count       (frame_count),
        .allBulletContents (allBulletContents),
        .allSpriteContents (allSpriteContents)
    );

    always #5 clk = ~clk;

    // Reference model: two banks as plain arrays plus scalar status
    logic [31:0] shadowM [NT];
    logic [31:0] visM    [NT];
    logic        dirtyM;
    logic        pulseM;
    logic [31:0] rdM;
    logic [15:0] fcM;

    int nAsserts = 0;
    int nFails   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] visWord(input int i);
        logic [31:0] w;
        if (i < NB) w = allBulletContents[i*32 +: 32];
        else        w = allSpriteContents[(i-NB)*32 +: 32];
        return w;
    endfunction

    function automatic logic [31:0] modelStore(input int a, input logic [31:0] d);
        logic [31:0] w;
        w = d;
`ifdef DISPLAY_STATE_CLIP_EN
        if (a < NB && (d[31:22] > 10'd628 || d[21:13] > 9'd468)) w[3] = 1'b0;
`endif
        return w;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NT; i++) begin
            shadowM[i] = '0;
            visM[i]    = '0;
        end
        dirtyM = 1'b0; pulseM = 1'b0; rdM = '0; fcM = '0;
    endtask

    task automatic checkAll();
        chk("rd_data", rd_data, rdM);
        chk("commit_pulse", commit_pulse, pulseM);
        chk("dirty", dirty, dirtyM);
        chk("frame_count", frame_count, fcM);
        for (int i = 0; i < NT; i++) chk($sformatf("visible[%0d]", i), visWord(i), visM[i]);
    endtask

    // One clock: drive inputs, update model with pre-edge state, then check
    task automatic cycle(input logic we, input int a, input logic [31:0] d,
                         input logic fe, input logic lk);
        logic commitNow;
        wr_en = we; addr = 7'(a); wr_data = d; frame_end = fe; lock = lk;
        @(posedge clk);
        commitNow = dirtyM && fe && !lk;
        rdM = (a < NT) ? shadowM[a] : 32'h0;
        if (commitNow) for (int i = 0; i < NT; i++) visM[i] = shadowM[i];
        pulseM = commitNow;
        if (fe) fcM = fcM + 16'd1;
        if (we && a < NT) begin
            shadowM[a] = modelStore(a, d);
            dirtyM = 1'b1;
        end else if (commitNow) begin
            dirtyM = 1'b0;
        end
        #1;
        checkAll();
    endtask

    initial begin
        logic [15:0] fc0;
        logic [31:0] clipWord;
        resetn = 1'b0; frame_end = 1'b0; wr_en = 1'b0; addr = '0; wr_data = '0; lock = 1'b0;
        modelReset();
        #3;
        checkAll();
        @(posedge clk); #1;
        resetn = 1'b1;

        // Single bullet store, published at the next frame boundary
        cycle(1, 5, 32'h0A014008, 0, 0);
        chk("bullet5_before_commit", allBulletContents[191:160], 32'h0);
        chk("dirty_after_write", dirty, 1'b1);
        cycle(0, 0, 0, 1, 0);
        chk("bullet5_after_commit", allBulletContents[191:160], 32'h0A014008);
        chk("commit_pulse_high", commit_pulse, 1'b1);
        cycle(0, 5, 0, 0, 0);
        chk("commit_pulse_once", commit_pulse, 1'b0);

        // Lock holds off the commit across frames
        fc0 = fcM;
        cycle(1, 64, 100, 0, 1);
        cycle(1, 65, 200, 0, 1);
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 1);
        chk("locked_no_commit", allSpriteContents[31:0], 32'h0);
        chk("locked_dirty", dirty, 1'b1);
        chk("locked_frame_count", frame_count, fc0 + 16'd2);
        cycle(0, 0, 0, 1, 0);
        chk("sprite0", allSpriteContents[31:0], 32'd100);
        chk("sprite1", allSpriteContents[63:32], 32'd200);
        chk("unlock_frame_count", frame_count, fc0 + 16'd3);

        // Store coincident with a committing frame boundary
        cycle(1, 2, 32'h22, 0, 0);
        cycle(1, 2, 32'h11, 1, 0);
        chk("coincident_visible", allBulletContents[95:64], 32'h22);
        chk("coincident_dirty", dirty, 1'b1);
        cycle(0, 0, 0, 1, 0);
        chk("coincident_next", allBulletContents[95:64], 32'h11);

        // Out-of-range store and read are no-ops
        cycle(1, 100, 32'hFFFFFFFF, 0, 0);
        chk("oor_dirty", dirty, 1'b0);
        cycle(0, 100, 0, 0, 0);
        chk("oor_rd", rd_data, 32'h0);

        // Off-screen bullet x=635 with active set
        clipWord = (32'd635 << 22) | (32'd10 << 13) | 32'h8;
        cycle(1, 7, clipWord, 0, 0);
        cycle(0, 7, 0, 1, 0);
        chk("clip_x_kept", allBulletContents[7*32+22 +: 10], 10'd635);
`ifdef DISPLAY_STATE_CLIP_EN
        chk("clip_active", allBulletContents[7*32+3], 1'b0);
`else
        chk("clip_active", allBulletContents[7*32+3], 1'b1);
`endif

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 1) == 1), int'($urandom_range(0, 99)), $urandom,
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0));
        end

        // Async reset mid-burst discards pending stores
        cycle(1, 10, 32'hAAAA5555, 0, 0);
        cycle(1, 66, 32'h12345678, 0, 0);
        cycle(1, 11, 32'hDEADBEEF, 0, 1);
        resetn = 1'b0;
        #1;
        modelReset();
        checkAll();
        @(posedge clk); #1;
        resetn = 1'b1;
        cycle(0, 0, 0, 1, 0);
        chk("no_commit_after_reset", commit_pulse, 1'b0);
        cycle(0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
